// File: rtl/simproc_loader_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// simproc_loader_pkg : shared types and constants for the simproc loader
// rev 1.0
// ----------------------------------------------------------------------------
package simproc_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    LEN   = 3'd2,
    DATA  = 3'd3,
    CSUM  = 3'd4,
    SETPC = 3'd5,
    RUN   = 3'd6
  } loader_state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // The stream is only accepted while a frame can still be parsed.
  function automatic logic loader_accepts(input loader_state_t s);
    return (s != SETPC) && (s != RUN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/simproc_loader_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// simproc_loader_if : stream, processor and memory-port signals of the loader
// rev 1.0
// ----------------------------------------------------------------------------
interface simproc_loader_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       abort;
  logic [7:0] proc_mem_addr;
  logic [7:0] proc_mem_din;
  logic       proc_mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_din;
  logic       mem_we;
  logic [7:0] pc_set_val;
  logic       pc_set_wr;
  logic       run;
  logic       done;

  modport slave (
    input  in_data, in_valid, abort, proc_mem_addr, proc_mem_din, proc_mem_we, done,
    output in_ready, mem_addr, mem_din, mem_we, pc_set_val, pc_set_wr, run
  );

  modport master (
    output in_data, in_valid, abort, proc_mem_addr, proc_mem_din, proc_mem_we, done,
    input  in_ready, mem_addr, mem_din, mem_we, pc_set_val, pc_set_wr, run
  );

endinterface
`default_nettype wire

// File: rtl/simproc_mem_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// simproc_mem_mux : 2:1 select of the memory address/data/write-enable triple
// rev 1.0
// ----------------------------------------------------------------------------
module simproc_mem_mux (
  input  logic       sel_proc_i,
  input  logic [7:0] ldr_addr_i,
  input  logic [7:0] ldr_din_i,
  input  logic       ldr_we_i,
  input  logic [7:0] proc_addr_i,
  input  logic [7:0] proc_din_i,
  input  logic       proc_we_i,
  output logic [7:0] mem_addr_o,
  output logic [7:0] mem_din_o,
  output logic       mem_we_o
);

  assign mem_addr_o = sel_proc_i ? proc_addr_i : ldr_addr_i;
  assign mem_din_o  = sel_proc_i ? proc_din_i  : ldr_din_i;
  assign mem_we_o   = sel_proc_i ? proc_we_i   : ldr_we_i;

endmodule
`default_nettype wire

// File: rtl/simproc_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// simproc_loader : loads a framed byte stream into program memory, then runs it
// rev 1.0
// ----------------------------------------------------------------------------
module simproc_loader
  import simproc_loader_pkg::*;
#(
  parameter logic [7:0] SYNC = SYNC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  simproc_loader_if.slave bus,
  output logic            busy_o,
  output logic            load_ok_o,
  output logic            load_err_o
);

  loader_state_t state_q;
  logic [7:0]    start_q;
  logic [7:0]    wr_ptr_q;
  logic [7:0]    remaining_q;
  logic [7:0]    csum_q;
  logic [7:0]    pc_set_val_q;
  logic          pc_set_wr_q;
  logic          run_q;
  logic          load_ok_q;
  logic          load_err_q;

  logic          w_ready;
  logic          w_accept;
  logic          w_ldr_we;

  assign w_ready  = loader_accepts(state_q);
  assign w_accept = bus.in_valid & w_ready;
  // The write lands on the same edge that accepts the DATA byte.
  assign w_ldr_we = w_accept & (state_q == DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      start_q      <= 8'h00;
      wr_ptr_q     <= 8'h00;
      remaining_q  <= 8'h00;
      csum_q       <= 8'h00;
      pc_set_val_q <= 8'h00;
      pc_set_wr_q  <= 1'b0;
      run_q        <= 1'b0;
      load_ok_q    <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      load_ok_q    <= 1'b0;
      pc_set_wr_q  <= 1'b0;
      pc_set_val_q <= 8'h00;
      case (state_q)
        IDLE: begin
          if (w_accept && (bus.in_data == SYNC)) begin
            state_q    <= ADDR;
            load_err_q <= 1'b0;
          end
        end
        ADDR: begin
          if (w_accept) begin
            start_q  <= bus.in_data;
            wr_ptr_q <= bus.in_data;
            csum_q   <= bus.in_data;
            state_q  <= LEN;
          end
        end
        LEN: begin
          if (w_accept) begin
            remaining_q <= bus.in_data;
            csum_q      <= csum_q + bus.in_data;
            state_q     <= (bus.in_data == 8'h00) ? CSUM : DATA;
          end
        end
        DATA: begin
          if (w_accept) begin
            wr_ptr_q    <= wr_ptr_q + 8'd1;
            remaining_q <= remaining_q - 8'd1;
            csum_q      <= csum_q + bus.in_data;
            if (remaining_q == 8'd1) begin
              state_q <= CSUM;
            end
          end
        end
        CSUM: begin
          // Written bytes stay in memory on mismatch; only the flag records it.
          if (w_accept) begin
            if (bus.in_data == csum_q) begin
              state_q      <= SETPC;
              pc_set_wr_q  <= 1'b1;
              pc_set_val_q <= start_q;
            end else begin
              state_q    <= IDLE;
              load_err_q <= 1'b1;
            end
          end
        end
        SETPC: begin
          state_q <= RUN;
          run_q   <= 1'b1;
        end
        RUN: begin
          if (bus.done) begin
            state_q   <= IDLE;
            run_q     <= 1'b0;
            load_ok_q <= 1'b1;
          end else if (bus.abort) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  simproc_mem_mux u_mem_mux (
    .sel_proc_i  (state_q == RUN),
    .ldr_addr_i  (wr_ptr_q),
    .ldr_din_i   (bus.in_data),
    .ldr_we_i    (w_ldr_we),
    .proc_addr_i (bus.proc_mem_addr),
    .proc_din_i  (bus.proc_mem_din),
    .proc_we_i   (bus.proc_mem_we),
    .mem_addr_o  (bus.mem_addr),
    .mem_din_o   (bus.mem_din),
    .mem_we_o    (bus.mem_we)
  );

  assign bus.in_ready   = w_ready;
  assign bus.pc_set_val = pc_set_val_q;
  assign bus.pc_set_wr  = pc_set_wr_q;
  assign bus.run        = run_q;
  assign busy_o         = (state_q != IDLE);
  assign load_ok_o      = load_ok_q;
  assign load_err_o     = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_simproc_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_simproc_loader : directed frames against a frame-level expectation model
// rev 1.0
// ----------------------------------------------------------------------------
module tb_simproc_loader;
  import simproc_loader_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic busy, load_ok, load_err;

  simproc_loader_if bus ();

  simproc_loader #(.SYNC(SYNC_DEFAULT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy_o     (busy),
    .load_ok_o  (load_ok),
    .load_err_o (load_err)
  );

  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pcwr = 0;
  int n_ok = 0;
  bit chk_en = 1'b0;

  logic       e_ready, e_busy, e_run, e_pcwr, e_ok, e_err, e_we;
  logic [7:0] e_pcval, e_addr, e_din;
  bit         m_err, m_ok_pend;
  logic [7:0] fr [0:15];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (rst_n) check("in_ready", 8'(bus.in_ready), 8'(e_ready));
      check("busy",       8'(busy),          8'(e_busy));
      check("run",        8'(bus.run),       8'(e_run));
      check("pc_set_wr",  8'(bus.pc_set_wr), 8'(e_pcwr));
      check("pc_set_val", bus.pc_set_val,    e_pcval);
      check("load_ok",    8'(load_ok),       8'(e_ok));
      check("load_err",   8'(load_err),      8'(e_err));
      check("mem_we",     8'(bus.mem_we),    8'(e_we));
      if (e_we) begin
        check("mem_addr", bus.mem_addr, e_addr);
        check("mem_din",  bus.mem_din,  e_din);
      end
      if (rst_n && bus.pc_set_wr) n_pcwr++;
      if (rst_n && load_ok) n_ok++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    m_ok_pend = 1'b0;
  endtask

  task automatic exp_idle();
    e_ready = 1'b1; e_busy = 1'b0; e_run = 1'b0; e_pcwr = 1'b0; e_pcval = 8'h00;
    e_ok = m_ok_pend; e_err = m_err; e_we = 1'b0; e_addr = 8'h00; e_din = 8'h00;
  endtask

  task automatic exp_loading();
    e_ready = 1'b1; e_busy = 1'b1; e_run = 1'b0; e_pcwr = 1'b0; e_pcval = 8'h00;
    e_ok = 1'b0; e_err = 1'b0; e_we = 1'b0; e_addr = 8'h00; e_din = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      exp_idle();
      bus.in_valid = 1'b0;
      tick();
    end
  endtask

  task automatic junk(input logic [7:0] b);
    exp_idle();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Frame = SYNC, ADDR, LEN, data..., checksum+cs_delta; stop_after>=0 truncates.
  task automatic send_frame(input logic [7:0] a, input int n, input logic [7:0] cs_delta,
                            input int gap_at, input int stop_after);
    logic [7:0] q[$];
    logic [7:0] sum;
    sum = a + 8'(n);
    q.push_back(SYNC_DEFAULT);
    q.push_back(a);
    q.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      q.push_back(fr[i]);
      sum = sum + fr[i];
    end
    q.push_back(sum + cs_delta);
    for (int i = 0; i < q.size(); i++) begin
      if (stop_after >= 0 && i >= stop_after) begin
        bus.in_valid = 1'b0;
        return;
      end
      if (i == gap_at) begin
        exp_loading();
        bus.in_valid = 1'b0;
        tick();
      end
      if (i == 0) exp_idle();
      else        exp_loading();
      if (i >= 3 && i < 3 + n) begin
        e_we   = 1'b1;
        e_addr = a + 8'(i - 3);
        e_din  = q[i];
        exp_mem[e_addr] = q[i];
      end
      bus.in_valid = 1'b1;
      bus.in_data  = q[i];
      tick();
      if (i == 0) m_err = 1'b0;
    end
    bus.in_valid = 1'b0;
    if (cs_delta == 8'h00) begin
      exp_loading();
      e_ready = 1'b0; e_pcwr = 1'b1; e_pcval = a;
      tick();
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic run_cyc(input bit dn, input bit ab, input bit pwe,
                         input logic [7:0] pa, input logic [7:0] pd);
    e_ready = 1'b0; e_busy = 1'b1; e_run = 1'b1; e_pcwr = 1'b0; e_pcval = 8'h00;
    e_ok = 1'b0; e_err = m_err; e_we = pwe; e_addr = pa; e_din = pd;
    bus.done = dn; bus.abort = ab; bus.proc_mem_we = pwe;
    bus.proc_mem_addr = pa; bus.proc_mem_din = pd;
    if (pwe) exp_mem[pa] = pd;
    tick();
    bus.done = 1'b0; bus.abort = 1'b0; bus.proc_mem_we = 1'b0;
    if (dn) m_ok_pend = 1'b1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    m_err = 1'b0;
    m_ok_pend = 1'b0;
    exp_idle();
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_idle();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.abort = 1'b0; bus.done = 1'b0;
    bus.proc_mem_we = 1'b0; bus.proc_mem_addr = 8'h00; bus.proc_mem_din = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      exp_mem[i] = 8'h00;
    end
    m_err = 1'b0;
    m_ok_pend = 1'b0;
    exp_idle();
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    do_reset(2);
    idle(2);

    // Basic load and run until done
    fr[0] = 8'h44; fr[1] = 8'h12;
    send_frame(8'h10, 2, 8'h00, -1, -1);
    run_cyc(0, 0, 0, 8'h00, 8'h00);
    run_cyc(0, 0, 0, 8'h00, 8'h00);
    run_cyc(0, 0, 0, 8'h00, 8'h00);
    run_cyc(1, 0, 0, 8'h00, 8'h00);
    idle(2);

    // Address wrap, with an input stall between the two data bytes
    fr[0] = 8'h01; fr[1] = 8'h02;
    send_frame(8'hFF, 2, 8'h00, 4, -1);
    run_cyc(1, 0, 0, 8'h00, 8'h00);
    idle(1);

    // Bad checksum (sent byte 00, correct 76)
    fr[0] = 8'h55;
    send_frame(8'h20, 1, 8'h8A, -1, -1);
    idle(2);

    // Junk then LEN=0 frame; processor write, then abort
    junk(8'h00);
    junk(8'h33);
    send_frame(8'h30, 0, 8'h00, -1, -1);
    run_cyc(0, 0, 1, 8'h40, 8'h99);
    run_cyc(0, 1, 0, 8'h00, 8'h00);
    idle(2);

    // done and abort together
    fr[0] = 8'h77;
    send_frame(8'h50, 1, 8'h00, -1, -1);
    run_cyc(1, 1, 0, 8'h00, 8'h00);
    idle(2);

    // Reset after three data bytes
    fr[0] = 8'h01; fr[1] = 8'h02; fr[2] = 8'h03; fr[3] = 8'h04; fr[4] = 8'h05;
    send_frame(8'h60, 5, 8'h00, -1, 6);
    do_reset(2);
    idle(2);

    send_frame(8'h30, 0, 8'h00, -1, -1);
    run_cyc(1, 0, 0, 8'h00, 8'h00);
    idle(2);
    chk_en = 1'b0;

    check("lit_mem10", mem[8'h10], 8'h44);
    check("lit_mem11", mem[8'h11], 8'h12);
    check("lit_memFF", mem[8'hFF], 8'h01);
    check("lit_mem00", mem[8'h00], 8'h02);
    check("lit_mem20", mem[8'h20], 8'h55);
    check("lit_mem40", mem[8'h40], 8'h99);
    check("lit_mem50", mem[8'h50], 8'h77);
    check("lit_mem62", mem[8'h62], 8'h03);
    check("lit_mem63", mem[8'h63], 8'h00);
    check("lit_pcwr_count", 8'(n_pcwr), 8'd5);
    check("lit_ok_count",   8'(n_ok),   8'd4);
    for (int i = 0; i < 256; i++) check("mem_content", mem[i], exp_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/simproc_loader.md
# simproc_loader

Program loader that sits directly upstream of `simproc`. It receives a framed byte stream over a valid/ready handshake and writes the payload into the shared 256×8 program memory. It then sets the processor PC to the load address and holds `run` until the processor reports `done`. While loading, it owns the memory port; during execution it passes the processor's memory signals through unchanged.

## Interface
- `SYNC`, default 8'hA5: frame start byte.
- `clk` in 1: system clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: loader accepts a byte this cycle.
- `abort` in 1: stop a running program.
- `proc_mem_addr` in 8, `proc_mem_din` in 8, `proc_mem_we` in 1: processor memory request.
- `mem_addr` out 8, `mem_din` out 8, `mem_we` out 1: to memory; read data goes straight from memory to the processor.
- `pc_set_val` out 8, `pc_set_wr` out 1, `run` out 1: to `simproc`.
- `done` in 1: from `simproc`.
- `busy` out 1: not in IDLE.
- `load_ok` out 1: one-cycle pulse when the program completes.
- `load_err` out 1: sticky checksum error.

## Operation
- Frame format: SYNC, ADDR, LEN, LEN data bytes, CSUM.
- CSUM = (ADDR + LEN + Σdata) mod 256.
- A byte is accepted when `in_valid & in_ready` is high at the clock edge.
- States:
  - IDLE: accepts bytes. SYNC → ADDR and clears `load_err`. Any other byte is discarded; stay in IDLE.
  - ADDR: latch `start` and `wr_ptr`; seed the checksum → LEN.
  - LEN: latch `remaining`. LEN=0 → CSUM, otherwise → DATA.
  - DATA: each accepted byte is written to mem[`wr_ptr`]. `wr_ptr` increments and wraps FF→00. `remaining` decrements; on the last byte → CSUM.
  - CSUM: on match → SETPC. On mismatch → IDLE with `load_err`=1. Bytes already written are not rolled back.
  - SETPC: one cycle; `pc_set_wr`=1, `pc_set_val`=`start` → RUN.
  - RUN: `run`=1 and memory is muxed to the processor.
    - First cycle with `done`=1 → IDLE with `load_ok` pulse.
    - `abort`=1 → IDLE with no pulse.
    - `done` and `abort` in the same cycle → `done` wins.
- `in_ready` = 1 in IDLE, ADDR, LEN, DATA and CSUM; 0 in SETPC and RUN.
- Memory mux:
  - In RUN, `mem_*` = `proc_mem_*`.
  - Otherwise `mem_addr`=`wr_ptr`, `mem_din`=`in_data`, and `mem_we`=`in_valid & in_ready` while in DATA.

## Timing
- Reset: state IDLE; all outputs 0 except `in_ready`=1 once `rst_n` is high; `mem_*` driven from the loader side with `mem_we`=0.
- Memory write occurs in the same clock edge that accepts the DATA byte; `mem_we` is combinational from state and handshake.
- Minimum frame cost: LEN+4 accepted cycles.
- SYNC to first `run` cycle: LEN+5 cycles at full input rate.
- `load_ok` and `load_err` assert in the cycle after the deciding edge.
- `run` drops in that same cycle.
- `in_valid` gaps stall the FSM indefinitely; there is no timeout.
- Reset mid-frame or mid-run returns the FSM to IDLE. Memory contents are kept and the frame must be resent.

## Structure
- `simproc_loader_pkg`: `loader_state_t` enum (IDLE, ADDR, LEN, DATA, CSUM, SETPC, RUN) and `SYNC_DEFAULT`.
- One sub-module, `simproc_mem_mux`: combinational 2:1 selection of the address, data and write-enable triple.
- FSM, counters and checksum accumulator live in the top module.

## Test plan
- Frame A5 10 02 44 12 68: mem[10]=44, mem[11]=12; `pc_set_wr` pulse with `pc_set_val`=10; `run`=1 until `done`; `load_ok` pulse.
- Wrap frame A5 FF 02 01 02 04: mem[FF]=01, mem[00]=02, `pc_set_val`=FF.
- Bad checksum A5 20 01 55 00: mem[20]=55, `load_err`=1, no `pc_set_wr`, no `run`. A following valid frame clears `load_err`.
- Junk bytes 00 33 then A5 30 00 30 (LEN=0): junk ignored; `pc_set_val`=30; no memory writes.
- In RUN with `proc_mem_we`=1, `proc_mem_addr`=40, `proc_mem_din`=99: mem[40]=99; `in_ready`=0.
  - Then `abort` with `done` low: `run` drops and there is no `load_ok`.
  - Then `done` and `abort` together: `load_ok` pulses.
- `rst_n` low after 3 DATA bytes: FSM returns to IDLE with outputs at their reset values; the 3 bytes remain in memory.
